// File: rtl/pc_unit.sv
// Program counter with branch/jump/return/trap sources and a circular return-address stack.
// PC advances only on the write-back phase when not stalled.
module pc_unit #(
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_VEC  = '0,
  parameter logic [XLEN-1:0]   STEP       = XLEN'(4),
  parameter int                ALIGN_BITS = 2,
  parameter int                RAS_DEPTH  = 4,
  parameter int                PHASE_W    = 5,
  parameter int                W_IDX      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PHASE_W-1:0]             phase,
  input  logic                           stall,
  input  logic [1:0]                     sel,
  input  logic [XLEN-1:0]                offset,
  input  logic [XLEN-1:0]                target,
  input  logic                           call,
  input  logic                           trap,
  input  logic [XLEN-1:0]                trap_vec,
  output logic [XLEN-1:0]                pc_reg,
  output logic [XLEN-1:0]                epc_reg,
  output logic [$clog2(RAS_DEPTH):0]     ras_cnt,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic                           misalign
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top_reg;

  logic            update;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] raw_next;
  logic [XLEN-1:0] pc_next;
  logic            push;
  logic            pop;
  logic            unf_set;
  logic            mis_set;
  logic [PW-1:0]   push_idx;

  assign update   = phase[W_IDX] && !stall;
  assign seq_pc   = pc_reg + STEP;
  assign push_idx = top_reg + PW'(1);

  always_comb begin
    raw_next = seq_pc;
    push     = 1'b0;
    pop      = 1'b0;
    unf_set  = 1'b0;
    if (trap) begin
      raw_next = trap_vec;
    end else begin
      case (sel)
        2'b00: raw_next = seq_pc;
        2'b01: raw_next = pc_reg + offset;
        2'b10: begin
          raw_next = target;
          push     = call;
        end
        default: begin
          if (ras_cnt != '0) begin
            raw_next = ras_mem[top_reg];
            pop      = 1'b1;
          end else begin
            unf_set  = 1'b1;
          end
        end
      endcase
    end
    // Misaligned targets are still taken, just with the low bits forced to zero.
    mis_set = |(raw_next & LOW_MASK);
    pc_next = raw_next & ~LOW_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg   <= RESET_VEC;
      epc_reg  <= '0;
      ras_cnt  <= '0;
      top_reg  <= '0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      misalign <= 1'b0;
    end else if (update) begin
      pc_reg <= pc_next;
      if (trap) epc_reg <= pc_reg;
      if (mis_set) misalign <= 1'b1;
      if (unf_set) ras_unf <= 1'b1;
      if (push) begin
        // Full stack: the write wraps over the oldest entry, count stays saturated.
        top_reg <= push_idx;
        if (ras_cnt == FULL_CNT) ras_ovf <= 1'b1;
        else                     ras_cnt <= ras_cnt + CW'(1);
      end else if (pop) begin
        top_reg <= top_reg - PW'(1);
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && update && push) ras_mem[push_idx] <= seq_pc;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential, branch, jump/call/return with RAS wrap,
// traps, stalls, misalignment and mid-sequence reset.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  phase;
  logic        stall;
  logic [1:0]  sel;
  logic [31:0] offset;
  logic [31:0] target;
  logic        call;
  logic        trap;
  logic [31:0] trap_vec;
  logic [31:0] pc_reg;
  logic [31:0] epc_reg;
  logic [2:0]  ras_cnt;
  logic        ras_ovf;
  logic        ras_unf;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] WP = 5'b10000;

  pc_unit dut (
    .clk(clk), .rst(rst), .phase(phase), .stall(stall), .sel(sel),
    .offset(offset), .target(target), .call(call), .trap(trap),
    .trap_vec(trap_vec), .pc_reg(pc_reg), .epc_reg(epc_reg),
    .ras_cnt(ras_cnt), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic r, input logic [4:0] ph, input logic st,
                     input logic [1:0] s, input logic [31:0] off,
                     input logic [31:0] tgt, input logic c, input logic tr,
                     input logic [31:0] tv);
    rst = r; phase = ph; stall = st; sel = s; offset = off;
    target = tgt; call = c; trap = tr; trap_vec = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic [4:0] ph);
    cyc(1'b0, ph, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic jmp(input logic [31:0] tgt, input logic c);
    cyc(1'b0, WP, 1'b0, 2'b10, 32'h0, tgt, c, 1'b0, 32'h0);
  endtask

  task automatic ret();
    cyc(1'b0, WP, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with write phase and trap asserted: reset must win.
    cyc(1'b1, WP, 1'b0, 2'b10, 32'h0, 32'h123, 1'b1, 1'b1, 32'h80);
    chk("rst_pc", pc_reg, 32'h0);
    chk("rst_epc", epc_reg, 32'h0);
    chk("rst_cnt", 32'(ras_cnt), 32'h0);
    chk("rst_flags", {29'h0, ras_ovf, ras_unf, misalign}, 32'h0);

    // Sequential stepping; non-write, multi-hot and zero phases must hold.
    seq(WP);       chk("seq1", pc_reg, 32'h4);
    seq(5'b00001); chk("hold_ph1", pc_reg, 32'h4);
    seq(5'b01111); chk("hold_multi", pc_reg, 32'h4);
    seq(5'b00000); chk("hold_zero", pc_reg, 32'h4);
    seq(WP);       chk("seq2", pc_reg, 32'h8);
    seq(WP);       chk("seq3", pc_reg, 32'hC);

    // Negative branch and wrap-around.
    jmp(32'h100, 1'b0); chk("jmp100", pc_reg, 32'h100);
    cyc(1'b0, WP, 1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("br_neg", pc_reg, 32'hF0);
    jmp(32'hFFFF_FFFC, 1'b0); chk("jmp_top", pc_reg, 32'hFFFF_FFFC);
    seq(WP);       chk("wrap", pc_reg, 32'h0);
    chk("wrap_noflag", {29'h0, ras_ovf, ras_unf, misalign}, 32'h0);

    // call with a branch select has no effect on the RAS.
    cyc(1'b0, WP, 1'b0, 2'b01, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("br_call_pc", pc_reg, 32'h8);
    chk("br_call_cnt", 32'(ras_cnt), 32'h0);

    // Five calls into a 4-deep RAS; pushed return addresses are caller PC + 4.
    jmp(32'h10, 1'b0);
    jmp(32'h100, 1'b1);
    jmp(32'h200, 1'b1);
    jmp(32'h300, 1'b1);
    jmp(32'h400, 1'b1);
    chk("cnt_full", 32'(ras_cnt), 32'h4);
    chk("ovf_not_yet", 32'(ras_ovf), 32'h0);
    jmp(32'h500, 1'b1);
    chk("call5_pc", pc_reg, 32'h500);
    chk("cnt_sat", 32'(ras_cnt), 32'h4);
    chk("ovf_set", 32'(ras_ovf), 32'h1);
    ret(); chk("ret1", pc_reg, 32'h404);
    ret(); chk("ret2", pc_reg, 32'h304);
    ret(); chk("ret3", pc_reg, 32'h204);
    ret(); chk("ret4", pc_reg, 32'h104);
    chk("cnt_empty", 32'(ras_cnt), 32'h0);
    chk("unf_not_yet", 32'(ras_unf), 32'h0);
    ret(); chk("ret_unf_pc", pc_reg, 32'h108);
    chk("unf_set", 32'(ras_unf), 32'h1);

    // Trap beats a jump+call: no push, EPC captures the trapping PC.
    jmp(32'h40, 1'b1);
    chk("call40_cnt", 32'(ras_cnt), 32'h1);
    cyc(1'b0, WP, 1'b0, 2'b10, 32'h0, 32'h999, 1'b1, 1'b1, 32'h80);
    chk("trap_pc", pc_reg, 32'h80);
    chk("trap_epc", epc_reg, 32'h40);
    chk("trap_cnt", 32'(ras_cnt), 32'h1);
    cyc(1'b0, WP, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200);
    chk("stall_trap", pc_reg, 32'h80);
    ret(); chk("ret_after_trap", pc_reg, 32'h10C);

    // Stall holds; misaligned target loads with low bits cleared.
    cyc(1'b0, WP, 1'b1, 2'b10, 32'h0, 32'h300, 1'b0, 1'b0, 32'h0);
    chk("stall_pc", pc_reg, 32'h10C);
    chk("mis_clear", 32'(misalign), 32'h0);
    jmp(32'h302, 1'b0);
    chk("mis_pc", pc_reg, 32'h300);
    chk("mis_set", 32'(misalign), 32'h1);

    // Build three RAS entries, then reset mid-sequence.
    jmp(32'h400, 1'b1);
    jmp(32'h500, 1'b1);
    jmp(32'h600, 1'b1);
    chk("cnt3", 32'(ras_cnt), 32'h3);
    chk("sticky", {29'h0, ras_ovf, ras_unf, misalign}, 32'h7);
    cyc(1'b1, WP, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80);
    chk("rst2_pc", pc_reg, 32'h0);
    chk("rst2_epc", epc_reg, 32'h0);
    chk("rst2_cnt", 32'(ras_cnt), 32'h0);
    chk("rst2_flags", {29'h0, ras_ovf, ras_unf, misalign}, 32'h0);
    ret();
    chk("post_rst_ret", pc_reg, 32'h4);
    chk("post_rst_unf", 32'(ras_unf), 32'h1);
    chk("post_rst_cnt", 32'(ras_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
